// File: rtl/operand_fetch_if.sv
// Operand-fetch bus bundle: upstream instruction handshake, regfile read and
// writeback taps, and the downstream operand handshake.
// The master modport is the environment around the stage; the slave modport
// is the operand_fetch stage itself.
interface operand_fetch_if #(
   parameter int TAG_W = 32
);
   // Pipeline control
   logic             Flush;

   // Upstream instruction handshake
   logic             InValid;
   logic             InReady;
   logic [4:0]       InRs;
   logic [4:0]       InRt;
   logic [TAG_W-1:0] InTag;

   // Register file read port
   logic [4:0]       ReadRegister1;
   logic [4:0]       ReadRegister2;
   logic [31:0]      ReadData1;
   logic [31:0]      ReadData2;

   // Writeback tap (same signals that write the register file)
   logic             WbRegWrite;
   logic [4:0]       WbRegister;
   logic [31:0]      WbData;

   // Downstream operand handshake
   logic             OutValid;
   logic             OutReady;
   logic [31:0]      OutA;
   logic [31:0]      OutB;
   logic [4:0]       OutRs;
   logic [4:0]       OutRt;
   logic [TAG_W-1:0] OutTag;

   modport master (
      output Flush,
      output InValid, InRs, InRt, InTag,
      input  InReady,
      input  ReadRegister1, ReadRegister2,
      output ReadData1, ReadData2,
      output WbRegWrite, WbRegister, WbData,
      input  OutValid, OutA, OutB, OutRs, OutRt, OutTag,
      output OutReady
   );

   modport slave (
      input  Flush,
      input  InValid, InRs, InRt, InTag,
      output InReady,
      output ReadRegister1, ReadRegister2,
      input  ReadData1, ReadData2,
      input  WbRegWrite, WbRegister, WbData,
      output OutValid, OutA, OutB, OutRs, OutRt, OutTag,
      input  OutReady
   );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: decode-to-execute operand stage behind the MIPS register file.
// Drives the regfile read addresses straight from the incoming instruction,
// captures the read data with a same-cycle writeback bypass, and presents the
// operands through a 2-entry skid buffer (main entry drives Out*, skid entry
// holds a second instruction while downstream stalls).
// Optional feature: define OPERAND_FETCH_SNOOP_EN to let every writeback also
// refresh operands that are already held in the main or skid entry.
module operand_fetch #(
   parameter int TAG_W = 32
) (
   input  logic          Clk,
   input  logic          Reset_n,
   operand_fetch_if.slave ofBus
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            stateReg;

   // Main entry (presented on Out*) and skid entry, lane 0 = A/Rs, lane 1 = B/Rt
   logic [1:0][31:0]  mainOpReg;
   logic [1:0][4:0]   mainSrcReg;
   logic [TAG_W-1:0]  mainTagReg;
   logic [1:0][31:0]  skidOpReg;
   logic [1:0][4:0]   skidSrcReg;
   logic [TAG_W-1:0]  skidTagReg;

   // Per-lane views of the incoming instruction and held operands
   logic [1:0][4:0]   srcAddr;
   logic [1:0][31:0]  readData;
   logic [1:0][31:0]  captureOp;
   logic [1:0][31:0]  mainOpHeld;
   logic [1:0][31:0]  skidOpHeld;

   logic              wbActive;
   logic              inReady;
   logic              outValid;
   logic              accept;
   logic              fire;

   // Handshake flags come from the registered state only, so InReady never
   // depends combinationally on OutReady.
   assign inReady  = (stateReg != TWO);
   assign outValid = (stateReg != EMPTY);
   assign accept   = ofBus.InValid && inReady;
   assign fire     = outValid && ofBus.OutReady;

   // A write to register 0 is discarded by the regfile, so it never bypasses.
   assign wbActive = ofBus.WbRegWrite && (ofBus.WbRegister != 5'd0);

   assign srcAddr[0]  = ofBus.InRs;
   assign srcAddr[1]  = ofBus.InRt;
   assign readData[0] = ofBus.ReadData1;
   assign readData[1] = ofBus.ReadData2;

   // The regfile read ports are asynchronous, so addresses go straight through.
   assign ofBus.ReadRegister1 = ofBus.InRs;
   assign ofBus.ReadRegister2 = ofBus.InRt;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : gLane
         // The regfile only shows a write after the edge, so a write landing
         // in the same cycle as the read must be forwarded here.
         assign captureOp[gi] = (wbActive && (ofBus.WbRegister == srcAddr[gi]))
                                ? ofBus.WbData : readData[gi];
`ifdef OPERAND_FETCH_SNOOP_EN
         // Held operands follow later writes to their source register, so an
         // entry stalled behind a writeback never goes stale.
         assign mainOpHeld[gi] = (wbActive && (ofBus.WbRegister == mainSrcReg[gi]))
                                 ? ofBus.WbData : mainOpReg[gi];
         assign skidOpHeld[gi] = (wbActive && (ofBus.WbRegister == skidSrcReg[gi]))
                                 ? ofBus.WbData : skidOpReg[gi];
`else
         // Held operands keep the value captured at accept time.
         assign mainOpHeld[gi] = mainOpReg[gi];
         assign skidOpHeld[gi] = skidOpReg[gi];
`endif
      end
   endgenerate

   // Skid-buffer FSM: moves entries between input, skid and main in FIFO order.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         stateReg   <= EMPTY;
         mainOpReg  <= '0;
         mainSrcReg <= '0;
         mainTagReg <= '0;
         skidOpReg  <= '0;
         skidSrcReg <= '0;
         skidTagReg <= '0;
      end else begin
         // Held operands refresh every cycle (a no-op unless snooping is on).
         mainOpReg <= mainOpHeld;
         skidOpReg <= skidOpHeld;

         if (ofBus.Flush) begin
            // Flush beats everything, including a same-cycle accept.
            stateReg <= EMPTY;
         end else begin
            case (stateReg)
               EMPTY: begin
                  if (accept) begin
                     mainOpReg  <= captureOp;
                     mainSrcReg <= srcAddr;
                     mainTagReg <= ofBus.InTag;
                     stateReg   <= ONE;
                  end
               end
               ONE: begin
                  if (accept && fire) begin
                     // Presented entry leaves, new one takes its place.
                     mainOpReg  <= captureOp;
                     mainSrcReg <= srcAddr;
                     mainTagReg <= ofBus.InTag;
                  end else if (accept) begin
                     // Downstream stalled: park the newcomer in the skid slot.
                     skidOpReg  <= captureOp;
                     skidSrcReg <= srcAddr;
                     skidTagReg <= ofBus.InTag;
                     stateReg   <= TWO;
                  end else if (fire) begin
                     stateReg   <= EMPTY;
                  end
               end
               TWO: begin
                  if (fire) begin
                     // Promote the older parked entry, with any snooped update.
                     mainOpReg  <= skidOpHeld;
                     mainSrcReg <= skidSrcReg;
                     mainTagReg <= skidTagReg;
                     stateReg   <= ONE;
                  end
               end
               default: begin
                  stateReg <= EMPTY;
               end
            endcase
         end
      end
   end

   assign ofBus.InReady  = inReady;
   assign ofBus.OutValid = outValid;
   assign ofBus.OutA     = mainOpReg[0];
   assign ofBus.OutB     = mainOpReg[1];
   assign ofBus.OutRs    = mainSrcReg[0];
   assign ofBus.OutRt    = mainSrcReg[1];
   assign ofBus.OutTag   = mainTagReg;

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-to-execute operand stage sitting directly downstream of the MIPS register file.
- Drives the regfile's two asynchronous read addresses from the incoming instruction and captures ReadData1/ReadData2.
- Bypasses same-cycle writeback data, because regfile writes only become visible after the clock edge.
- Presents operands to the ALU stage through a 2-entry skid buffer with a valid/ready handshake and flush.

Parameters:
TAG_W, 32, width of the opaque instruction payload carried alongside operands

Ports:
Clk  input  1  clock, all state updates on posedge
Reset_n  input  1  asynchronous active-low reset
Flush  input  1  discard all held entries and any same-cycle accept
InValid  input  1  upstream instruction valid
InReady  output  1  stage can accept; high when fewer than 2 entries held
InRs  input  5  first source register address
InRt  input  5  second source register address
InTag  input  TAG_W  instruction payload
ReadRegister1  output  5  to regfile; combinational copy of InRs
ReadRegister2  output  5  to regfile; combinational copy of InRt
ReadData1  input  32  from regfile
ReadData2  input  32  from regfile
WbRegWrite  input  1  writeback enable (same signal as regfile RegWrite)
WbRegister  input  5  writeback address
WbData  input  32  writeback data
OutValid  output  1  operands valid
OutReady  input  1  downstream accepts
OutA  output  32  first operand
OutB  output  32  second operand
OutRs  output  5  first source address of presented entry
OutRt  output  5  second source address of presented entry
OutTag  output  TAG_W  payload of presented entry

Behaviour:
- Reset (async, Reset_n=0): state EMPTY; OutValid=0; OutA, OutB, OutRs, OutRt, OutTag = 0; skid contents = 0. InReady=1 while in EMPTY.
- accept = InValid & InReady; fire = OutValid & OutReady.
- Capture value for A: WbData if WbRegWrite & (WbRegister==InRs) & (InRs!=0); otherwise ReadData1. B is the same with InRt/ReadData2.
- Register 0 is never bypassed; a write to reg 0 is ignored.
- Latency: accepted at edge N, visible on Out* after edge N (1 cycle). Out* are registered outputs.
- States (main entry drives Out*; skid holds the second entry):
  - EMPTY: accept -> ONE, main<=capture.
  - ONE, accept & fire -> ONE, main<=capture.
  - ONE, accept & !fire -> TWO, skid<=capture.
  - ONE, !accept & fire -> EMPTY.
  - ONE, otherwise -> hold.
  - TWO (InReady=0): fire -> ONE, main<=skid; otherwise -> hold.
- OutValid = (state != EMPTY). InReady = (state != TWO), derived from registered state only.
- Order is strict FIFO; no entry is duplicated or dropped except by Flush or reset.
- Flush has priority over all other events: next state is EMPTY, OutValid=0 next cycle, and a same-cycle accept is discarded. Out* data need not be cleared.
- Reset asserted mid-operation drops all entries immediately.
- Out* are stable while OutValid & !OutReady. The only exception is snoop updates under the optional feature.

Optional Feature:
- Macro: OPERAND_FETCH_SNOOP_EN.
- Defined: every posedge with WbRegWrite & WbRegister!=0 updates held operands whose source address equals WbRegister. This applies to main A/B and skid A/B. A skid->main promotion in the same cycle carries the updated value.
- Not defined: held entries keep the values captured at accept; only capture-time bypass applies.

Test Plan:
- Reset: Reset_n=0 mid-stream -> OutValid=0, Out*=0 immediately, InReady=1 after release.
- Basic: regfile r5=0x11, r6=0x22; accept Rs=5, Rt=6, OutReady=1 -> next cycle OutA=0x11, OutB=0x22, OutValid=1.
- Bypass: same cycle as accept Rs=5, WbRegWrite=1, WbRegister=5, WbData=0xDEAD -> OutA=0xDEAD. Repeat with Rs=0, WbRegister=0 -> OutA=0.
- Backpressure: OutReady=0, three back-to-back InValid tags 1,2,3 -> InReady drops after tag 2; raising OutReady gives tags 1,2,3 in order, none lost.
- Flush: state TWO with InValid=1 and Flush=1 -> next cycle OutValid=0, InReady=1, incoming tag absent.
- Snoop (macro defined): hold entry Rs=7 (OutA=0x5), write r7=0x9 -> OutA=0x9 next cycle. Without macro -> OutA stays 0x5.
